// File: rtl/split_ram_ctrl_pkg.sv
// Shared types and width helpers for the banked layer-buffer sequencer.
package split_ram_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, FIN} ctrl_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/split_ram_rd_fifo.sv
// Two-entry registered FIFO buffering buffer read data toward the compute datapath.
module split_ram_rd_fifo
  import split_ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  // Head is always the oldest entry, so dout is a plain register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) head <= din;
          else             tail <= din;
          count <= count + 1'b1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 1'b1;
        end
        2'b11: begin
          if (count == FIFO_CNT_W'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = head;

endmodule

// File: rtl/split_ram_ctrl.sv
// Sequencer for the banked layer buffer: bank-interleaved LOAD scatter and
// backpressured all-bank READ streaming through a small output FIFO.
module split_ram_ctrl
  import split_ram_ctrl_pkg::*;
#(
  parameter int NUM_RAMS  = 8,
  parameter int RAM_DEPTH = 256,
  parameter int RAM_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start_load,
  input  logic                              cfg_start_read,
  input  logic [len_width(RAM_DEPTH)-1:0]   cfg_len,
  input  logic [RAM_WIDTH-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [RAM_WIDTH-1:0]              ram_wr_data,
  output logic [NUM_RAMS-1:0]               ram_wren,
  output logic [addr_width(RAM_DEPTH)-1:0]  ram_addr,
  input  logic [NUM_RAMS*RAM_WIDTH-1:0]     ram_rd_data,
  output logic [NUM_RAMS*RAM_WIDTH-1:0]     out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int AW = addr_width(RAM_DEPTH);
  localparam int LW = len_width(RAM_DEPTH);
  localparam int BW = addr_width(NUM_RAMS);
  localparam int DW = NUM_RAMS * RAM_WIDTH;

  ctrl_state_t           state;
  logic [BW-1:0]         bank_cnt;
  logic [AW-1:0]         addr_cnt;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         last_addr;
  logic [LW-1:0]         len_reg;
  logic                  inflight;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  wr_fire;
  logic                  wr_last;
  logic                  pop;
  logic                  issue;
  logic                  drain_done;

  assign wr_fire = (state == LOAD) && in_valid;
  assign wr_last = (bank_cnt == BW'(NUM_RAMS - 1)) && ({1'b0, addr_cnt} == len_reg - LW'(1));
  assign pop     = out_valid && out_ready;
  // Occupancy after this cycle's pop must leave room for the new read's return
  assign issue   = (state == READ) &&
                   (({1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, inflight}) <
                    (3'(FIFO_DEPTH) + {{FIFO_CNT_W{1'b0}}, pop}));
  assign drain_done = !inflight && (fifo_count == FIFO_CNT_W'(pop));

  always_comb begin
    ram_addr    = last_addr;
    ram_wren    = '0;
    ram_wr_data = '0;
    if (wr_fire) begin
      ram_addr    = addr_cnt;
      ram_wren    = {{(NUM_RAMS-1){1'b0}}, 1'b1} << bank_cnt;
      ram_wr_data = in_data;
    end else if (issue) begin
      ram_addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bank_cnt  <= '0;
      addr_cnt  <= '0;
      rd_addr   <= '0;
      last_addr <= '0;
      len_reg   <= '0;
      inflight  <= 1'b0;
    end else begin
      last_addr <= ram_addr;
      inflight  <= issue;
      case (state)
        IDLE: begin
          if (cfg_start_load || cfg_start_read) begin
            len_reg  <= cfg_len;
            bank_cnt <= '0;
            addr_cnt <= '0;
            rd_addr  <= '0;
            if (cfg_len == '0)       state <= FIN;
            else if (cfg_start_load) state <= LOAD;
            else                     state <= READ;
          end
        end
        LOAD: begin
          if (wr_fire) begin
            if (wr_last) state <= FIN;
            if (bank_cnt == BW'(NUM_RAMS - 1)) begin
              bank_cnt <= '0;
              addr_cnt <= addr_cnt + 1'b1;
            end else begin
              bank_cnt <= bank_cnt + 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            if ({1'b0, rd_addr} == len_reg - LW'(1)) state <= DRAIN;
          end
        end
        DRAIN:   if (drain_done) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  split_ram_rd_fifo #(.WIDTH(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (ram_rd_data),
    .dout  (out_data),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_split_ram_ctrl.sv
// Scoreboard bench for split_ram_ctrl with a behavioural banked buffer and
// a reference image of the buffer contents derived from the interleave rule.
module tb_split_ram_ctrl;

  localparam int NR = 4;
  localparam int DEPTH = 16;
  localparam int W = 16;
  localparam int DW = NR * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start_load = 1'b0;
  logic          cfg_start_read = 1'b0;
  logic [4:0]    cfg_len = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  ram_wr_data;
  logic [NR-1:0] ram_wren;
  logic [3:0]    ram_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;

  split_ram_ctrl #(.NUM_RAMS(NR), .RAM_DEPTH(DEPTH), .RAM_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cfg_start_load(cfg_start_load), .cfg_start_read(cfg_start_read),
    .cfg_len(cfg_len), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_wr_data(ram_wr_data), .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_rd_data(ram_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural buffer: one-cycle read latency, per-bank write enable
  logic [W-1:0] mem [NR][DEPTH];
  logic [W-1:0] ref_mem [NR][DEPTH];
  initial begin
    for (int b = 0; b < NR; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mem[b][a] = '0;
        ref_mem[b][a] = '0;
      end
  end
  always @(posedge clk) begin
    for (int b = 0; b < NR; b++) begin
      if (ram_wren[b]) mem[b][ram_addr] <= ram_wr_data;
      ram_rd_data[b*W +: W] <= mem[b][ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [DW-1:0] data; int cyc; } beat_t;
  typedef struct { logic [NR-1:0] wren; logic [3:0] addr; logic [W-1:0] data; } wr_t;
  beat_t exp_beats[$];
  wr_t   exp_wr[$];
  beat_t cur_beat;
  wr_t   cur_wr;

  int            c0 = 0;
  int            beats_seen = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            rdy_mode = 0;
  bit            read_active = 0;
  int            read_len = 1;

  // Monitor: writes and read beats are popped from the scoreboard as they appear
  always @(negedge clk) begin
    if (rst) begin
      if (ram_wren != '0) begin
        check("wr_on_handshake", 64'(in_valid & in_ready), 64'(1));
        if (exp_wr.size() == 0) check("wr_unexpected", 64'(ram_wren), 64'(0));
        else begin
          cur_wr = exp_wr.pop_front();
          check("wr_wren", 64'(ram_wren), 64'(cur_wr.wren));
          check("wr_addr", 64'(ram_addr), 64'(cur_wr.addr));
          check("wr_data", 64'(ram_wr_data), 64'(cur_wr.data));
        end
      end else if (in_valid && in_ready) begin
        check("wr_missing", 64'(ram_wren != '0), 64'(1));
      end
      if (read_active) check("rd_addr_range", 64'(int'(ram_addr) <= read_len - 1), 64'(1));
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        beats_seen <= beats_seen + 1;
        if (exp_beats.size() == 0) check("beat_unexpected", 64'(out_valid), 64'(0));
        else begin
          cur_beat = exp_beats.pop_front();
          check("beat_data", out_data, cur_beat.data);
          if (cur_beat.cyc >= 0) check("beat_cycle", 64'(cyc - c0), 64'(cur_beat.cyc));
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_wren"}, 64'(ram_wren), 64'(0));
    check({tag, "_addr"}, 64'(ram_addr), 64'(0));
    check({tag, "_wr_data"}, 64'(ram_wr_data), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, out_data, 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
  endtask

  task automatic start_job(input bit ld, input bit rd, input int len);
    @(posedge clk); #1;
    cfg_start_load = ld;
    cfg_start_read = rd;
    cfg_len = 5'(len);
    c0 = cyc;
    @(posedge clk); #1;
    cfg_start_load = 1'b0;
    cfg_start_read = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int n = 0;
    forever begin
      @(negedge clk); #1;
      if (done) break;
      n++;
      if (n > 300) begin
        check({tag, "_done_timeout"}, 64'(done), 64'(1));
        return;
      end
    end
    check({tag, "_busy_in_fin"}, 64'(busy), 64'(1));
    if (exp_cyc >= 0) check({tag, "_done_cycle"}, 64'(cyc - c0), 64'(exp_cyc));
    @(negedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    check({tag, "_idle_after"}, 64'(busy), 64'(0));
  endtask

  // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0,1..., 2 random gaps
  task automatic load_job(input int len, input int gap_mode, input bit both, input bit rand_data);
    int n;
    logic [W-1:0] w;
    start_job(1'b1, both, len);
    if (both) check("both_starts_load", 64'(in_ready), 64'(1));
    for (int k = 0; k < len * NR; k++) begin
      w = rand_data ? W'($urandom) : W'(k + 1);
      exp_wr.push_back('{wren: NR'(1) << (k % NR), addr: 4'(k / NR), data: w});
      ref_mem[k % NR][k / NR] = w;
      in_data = w;
      in_valid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        n++;
        if (n > 50) begin
          check("load_handshake_timeout", 64'(in_ready), 64'(1));
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (k < len * NR - 1) begin
        n = (gap_mode == 1) ? ((k % 2 == 0) ? 2 : 0) :
            (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin @(posedge clk); #1; end
      end
    end
    @(negedge clk); #1;
    check("load_done_after_last", 64'(done), 64'(1));
    check("load_in_ready_fin", 64'(in_ready), 64'(0));
    @(negedge clk); #1;
    check("load_done_one_cycle", 64'(done), 64'(0));
    check("load_in_ready_after", 64'(in_ready), 64'(0));
    check("load_writes_drained", 64'(exp_wr.size()), 64'(0));
  endtask

  function automatic logic [DW-1:0] ref_word(input int a);
    logic [DW-1:0] r;
    for (int b = 0; b < NR; b++) r[b*W +: W] = ref_mem[b][a];
    return r;
  endfunction

  task automatic read_job(input int len, input bit timed, input bit poke);
    for (int a = 0; a < len; a++) exp_beats.push_back('{data: ref_word(a), cyc: timed ? 3 + a : -1});
    read_len = len;
    start_job(1'b0, 1'b1, len);
    read_active = 1;
    if (poke) begin
      @(posedge clk); #1;
      cfg_start_load = 1'b1;
      cfg_len = 5'd1;
      @(posedge clk); #1;
      cfg_start_load = 1'b0;
      check("busy_start_ignored", 64'(in_ready), 64'(0));
    end
    wait_done("read", timed ? len + 3 : -1);
    read_active = 0;
    check("read_all_beats", 64'(exp_beats.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int b0;
    int len;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    // Sequential words scattered across 4 banks x 3 addresses
    load_job(3, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("mem_b0_a0", 64'(mem[0][0]), 64'h0001);
    check("mem_b1_a0", 64'(mem[1][0]), 64'h0002);
    check("mem_b3_a2", 64'(mem[3][2]), 64'h000C);

    rdy_mode = 0;
    read_job(3, 1'b1, 1'b0);
    rdy_mode = 1;
    read_job(3, 1'b0, 1'b0);

    load_job(3, 1, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3 * NR; k++)
      check("mem_gapped_load", 64'(mem[k % NR][k / NR]), 64'(k + 1));

    // Reset after the first beat aborts the read without done
    rdy_mode = 0;
    for (int a = 0; a < 3; a++) exp_beats.push_back('{data: ref_word(a), cyc: -1});
    b0 = beats_seen;
    start_job(1'b0, 1'b1, 3);
    n = 0;
    forever begin
      @(negedge clk); #2;
      if (beats_seen > b0) break;
      n++;
      if (n > 50) begin
        check("first_beat_timeout", 64'(beats_seen > b0), 64'(1));
        break;
      end
    end
    rst = 1'b0;
    #1;
    check_idle_outputs("midjob_reset");
    exp_beats.delete();
    repeat (3) begin @(negedge clk); check("no_done_in_reset", 64'(done), 64'(0)); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("no_done_after_reset", 64'(done), 64'(0));
    read_job(3, 1'b1, 1'b0);

    // Zero-length job: done one cycle after the start, no RAM access
    start_job(1'b1, 1'b0, 0);
    wait_done("len0", 1);

    read_job(3, 1'b1, 1'b1);
    load_job(1, 0, 1'b1, 1'b1);

    // Full depth: last address is DEPTH-1
    load_job(DEPTH, 2, 1'b0, 1'b1);
    rdy_mode = 0;
    read_job(DEPTH, 1'b1, 1'b0);
    rdy_mode = 2;
    read_job(DEPTH, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      len = int'($urandom_range(1, DEPTH));
      load_job(len, 2, 1'b0, 1'b1);
      rdy_mode = 2;
      read_job(int'($urandom_range(1, len)), 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
